// File: rtl/tdes_pkg.sv
// Shared types and widths for the Triple-DES job sequencer and its helpers.
package tdes_pkg;

   localparam int BLOCK_W   = 64;
   localparam int MSG_SEL_W = 4;
   localparam int KEY_SEL_W = 3;

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      P1_GO,
      P1_WAIT,
      P2_GO,
      P2_WAIT,
      P3_GO,
      P3_WAIT,
      DONE,
      ERR
   } state_t;

   // True in the launch cycle of any of the three DES passes.
   function automatic logic is_go(input state_t s);
      return (s == P1_GO) || (s == P2_GO) || (s == P3_GO);
   endfunction

   // True while waiting on the core for any of the three passes.
   function automatic logic is_wait(input state_t s);
      return (s == P1_WAIT) || (s == P2_WAIT) || (s == P3_WAIT);
   endfunction

endpackage

// File: rtl/start_edge_detect.sv
// Registered rising-edge detector for already-synchronized button levels.
module start_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic rise
);

   logic level_q;

   // Delay the level one cycle and flag a 0->1 transition as a registered pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= 1'b0;
         rise    <= 1'b0;
      end else begin
         level_q <= level;
         rise    <= level & ~level_q;
      end
   end

endmodule

// File: rtl/tdes_job_sequencer.sv
// Runs one Triple-DES job (K1, K2, K1) through a shared single DES core.
module tdes_job_sequencer
   import tdes_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TO_W           = 11
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 mode,
   input  logic [MSG_SEL_W-1:0] message_sw,
   input  logic [KEY_SEL_W-1:0] key1_sw,
   input  logic [KEY_SEL_W-1:0] key2_sw,
   output logic [MSG_SEL_W-1:0] tbl_msg_sel,
   output logic [KEY_SEL_W-1:0] tbl_k1_sel,
   output logic [KEY_SEL_W-1:0] tbl_k2_sel,
   input  logic [BLOCK_W-1:0]   tbl_msg,
   input  logic [BLOCK_W-1:0]   tbl_k1,
   input  logic [BLOCK_W-1:0]   tbl_k2,
   output logic                 des_start,
   output logic                 des_decrypt,
   output logic [BLOCK_W-1:0]   des_key,
   output logic [BLOCK_W-1:0]   des_din,
   input  logic                 des_done,
   input  logic [BLOCK_W-1:0]   des_dout,
   output logic                 busy,
   output logic [BLOCK_W-1:0]   result,
   output logic                 result_valid,
   output logic                 err
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);

   state_t               state, state_nxt;
   logic                 req;
   logic                 mode_q;
   logic [BLOCK_W-1:0]   k1_q, k2_q, blk_q;
   logic [TO_W-1:0]      to_cnt;
   logic                 timeout_hit;
   logic                 in_pass;
   logic                 second_pass;

   start_edge_detect u_start_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .level (start),
      .rise  (req)
   );

   assign timeout_hit = (to_cnt >= TO_LAST);
   assign in_pass     = is_go(state) || is_wait(state);
   assign second_pass = (state == P2_GO) || (state == P2_WAIT);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state selection; core completion only counts while waiting on it.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = LOAD;
         LOAD:    state_nxt = P1_GO;
         P1_GO:   state_nxt = P1_WAIT;
         P2_GO:   state_nxt = P2_WAIT;
         P3_GO:   state_nxt = P3_WAIT;
         P1_WAIT: if (des_done) state_nxt = P2_GO;
                  else if (timeout_hit) state_nxt = ERR;
         P2_WAIT: if (des_done) state_nxt = P3_GO;
                  else if (timeout_hit) state_nxt = ERR;
         P3_WAIT: if (des_done) state_nxt = DONE;
                  else if (timeout_hit) state_nxt = ERR;
         DONE:    state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Core-facing and status outputs decoded from state; data is forced to 0 outside passes.
   always_comb begin
      des_start    = is_go(state);
      des_decrypt  = in_pass & (mode_q ^ second_pass);
      des_key      = '0;
      des_din      = '0;
      if (in_pass) begin
         des_key = second_pass ? k2_q : k1_q;
         des_din = blk_q;
      end
      busy         = (state != IDLE) && (state != DONE) && (state != ERR);
      result_valid = (state == DONE);
      err          = (state == ERR);
   end

   // Job datapath: switch latch, table capture, pass chaining, timeout count, result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tbl_msg_sel <= '0;
         tbl_k1_sel  <= '0;
         tbl_k2_sel  <= '0;
         mode_q      <= 1'b0;
         k1_q        <= '0;
         k2_q        <= '0;
         blk_q       <= '0;
         to_cnt      <= '0;
         result      <= '0;
      end else begin
         if (state == IDLE && req) begin
            tbl_msg_sel <= message_sw;
            tbl_k1_sel  <= key1_sw;
            tbl_k2_sel  <= key2_sw;
            mode_q      <= mode;
         end
         if (state == LOAD) begin
            blk_q <= tbl_msg;
            k1_q  <= tbl_k1;
            k2_q  <= tbl_k2;
         end
         if (is_go(state)) to_cnt <= '0;
         if (is_wait(state)) begin
            if (to_cnt < TO_MAX) to_cnt <= to_cnt + 1'b1;
            if (des_done) begin
               blk_q <= des_dout;
               // Loading result on the P3 completion makes it valid in the DONE cycle.
               if (state == P3_WAIT) result <= des_dout;
            end
         end
      end
   end

endmodule

// File: tb/tb_tdes_job_sequencer.sv
// Self-checking bench: stub DES core (dout = din ^ key, 4-cycle latency) and a pass-level model.
module tb_tdes_job_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, mode;
   logic [3:0]  message_sw;
   logic [2:0]  key1_sw, key2_sw;
   logic [3:0]  tbl_msg_sel;
   logic [2:0]  tbl_k1_sel, tbl_k2_sel;
   logic [63:0] tbl_msg, tbl_k1, tbl_k2;
   logic        des_start, des_decrypt;
   logic [63:0] des_key, des_din;
   logic        des_done;
   logic [63:0] des_dout;
   logic        busy;
   logic [63:0] result;
   logic        result_valid, err;

   logic [63:0] msg_tab [16];
   logic [63:0] k1_tab  [8];
   logic [63:0] k2_tab  [8];

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic        dec;
      logic [63:0] key;
      logic [63:0] din;
   } pass_t;
   pass_t mon_q [$];

   // Stub core state
   int          stub_cnt = 0;
   logic [63:0] stub_val = '0;
   logic        stub_done = 1'b0;
   bit          stub_en = 1'b1;
   logic        spur_done = 1'b0;

   always #5 clk = ~clk;

   assign tbl_msg  = msg_tab[tbl_msg_sel];
   assign tbl_k1   = k1_tab[tbl_k1_sel];
   assign tbl_k2   = k2_tab[tbl_k2_sel];
   assign des_done = stub_done | spur_done;
   assign des_dout = stub_val;

   tdes_job_sequencer #(.TIMEOUT_CYCLES(1024), .TO_W(11)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
      .message_sw(message_sw), .key1_sw(key1_sw), .key2_sw(key2_sw),
      .tbl_msg_sel(tbl_msg_sel), .tbl_k1_sel(tbl_k1_sel), .tbl_k2_sel(tbl_k2_sel),
      .tbl_msg(tbl_msg), .tbl_k1(tbl_k1), .tbl_k2(tbl_k2),
      .des_start(des_start), .des_decrypt(des_decrypt), .des_key(des_key), .des_din(des_din),
      .des_done(des_done), .des_dout(des_dout),
      .busy(busy), .result(result), .result_valid(result_valid), .err(err)
   );

   // Stub core: done is high exactly 4 cycles after the des_start cycle; it is never reset.
   always @(posedge clk) begin
      stub_done <= 1'b0;
      if (stub_cnt > 0) begin
         stub_cnt <= stub_cnt - 1;
         if (stub_cnt == 1 && stub_en) stub_done <= 1'b1;
      end
      if (des_start) begin
         stub_cnt <= 3;
         stub_val <= des_din ^ des_key;
      end
   end

   // Record every launch the DUT makes.
   always @(posedge clk) begin
      if (des_start) mon_q.push_back('{dec: des_decrypt, key: des_key, din: des_din});
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Launch one job from the current cycle and check it against the pass-level model.
   task automatic run_job(input logic [3:0] m, input logic [2:0] a, input logic [2:0] b,
                          input logic md, input int flip_at, input int spur_at,
                          input string tag, output logic [63:0] res);
      logic [63:0] ekey [3];
      logic [63:0] edin [3];
      logic        edec [3];
      logic [63:0] blk;
      int          n;
      bit          got;
      blk = msg_tab[m];
      for (int p = 0; p < 3; p++) begin
         ekey[p] = (p == 1) ? k2_tab[b] : k1_tab[a];
         edec[p] = (p == 1) ? ~md : md;
         edin[p] = blk;
         blk     = blk ^ ekey[p];
      end
      res = blk;
      mon_q.delete();
      message_sw = m; key1_sw = a; key2_sw = b; mode = md; start = 1'b1;
      n = 0; got = 0;
      while (!got && n < 100) begin
         @(posedge clk); #1; n++;
         if (n == 2) start = 1'b0;
         if (n == 3) begin
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_msgsel"}, tbl_msg_sel, m);
         end
         if (n == flip_at) message_sw = 4'hF;
         spur_done = (n == spur_at);
         if (result_valid || err) got = 1;
      end
      spur_done = 1'b0;
      chk({tag, "_latency"}, n, 18);
      chk({tag, "_result"}, result, blk);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_npass"}, mon_q.size(), 3);
      for (int p = 0; p < 3 && p < mon_q.size(); p++) begin
         chk($sformatf("%s_p%0d_dec", tag, p + 1), mon_q[p].dec, edec[p]);
         chk($sformatf("%s_p%0d_key", tag, p + 1), mon_q[p].key, ekey[p]);
         chk($sformatf("%s_p%0d_din", tag, p + 1), mon_q[p].din, edin[p]);
      end
      @(posedge clk); #1;
      chk({tag, "_rv_pulse"}, {result_valid, busy}, 0);
      chk({tag, "_result_hold"}, result, blk);
      chk({tag, "_msgsel_hold"}, tbl_msg_sel, m);
      message_sw = m;
   endtask

   initial begin
      logic [63:0] r, r_prev;
      int          n, rv_cnt, act;
      bit          got;
      logic [3:0]  m;
      logic [2:0]  a, b;
      logic        md;

      for (int i = 0; i < 16; i++) msg_tab[i] = {$urandom, $urandom};
      for (int i = 0; i < 8; i++) begin
         k1_tab[i] = {$urandom, $urandom};
         k2_tab[i] = {$urandom, $urandom};
      end
      msg_tab[0] = 64'h0123456789abcdef;
      k2_tab[0]  = 64'h96bcded6dc3f8d9a;

      rst_n = 1'b0; start = 1'b0; mode = 1'b0;
      message_sw = '0; key1_sw = '0; key2_sw = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", |{tbl_msg_sel, tbl_k1_sel, tbl_k2_sel, des_start, des_decrypt,
                          des_key, des_din, busy, result, result_valid, err}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Spurious done while idle
      spur_done = 1'b1;
      @(posedge clk); #1;
      spur_done = 1'b0;
      @(posedge clk); #1;
      chk("idle_spur", {busy, result_valid, err, des_start}, 0);

      // Reference encrypt job
      run_job(4'h0, 3'h0, 3'h0, 1'b0, 0, 0, "enc0", r);
      chk("enc0_known", result, 64'h979f9bb155944075);

      // Message switch moved during P1_WAIT
      run_job(4'h0, 3'h0, 3'h0, 1'b0, 5, 0, "flip", r);
      chk("flip_known", result, 64'h979f9bb155944075);

      // Randomized jobs, one with a spurious done in P2_GO
      for (int j = 0; j < 5; j++) begin
         m = 4'($urandom_range(0, 15)); a = 3'($urandom_range(0, 7));
         b = 3'($urandom_range(0, 7)); md = 1'($urandom_range(0, 1));
         run_job(m, a, b, md, 0, (j == 2) ? 8 : 0, $sformatf("rnd%0d", j), r);
      end

      // Start held high and re-pressed while busy: exactly one job
      m = 4'($urandom_range(0, 15)); a = 3'($urandom_range(0, 7)); b = 3'($urandom_range(0, 7));
      message_sw = m; key1_sw = a; key2_sw = b; mode = 1'b1; start = 1'b1;
      rv_cnt = 0; act = 0;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); #1;
         if (i == 5) start = 1'b0;
         if (i == 6) start = 1'b1;
         if (i == 12) start = 1'b0;
         if (i == 13) start = 1'b1;
         if (result_valid) rv_cnt++;
         if (des_start) act++;
      end
      chk("held_rv_count", rv_cnt, 1);
      chk("held_launches", act, 3);
      chk("held_result", result, msg_tab[m] ^ k2_tab[b]);
      start = 1'b0;
      @(posedge clk); #1;
      run_job(m, a, b, 1'b0, 0, 0, "second", r);

      // Timeout: core never completes
      r_prev = result;
      stub_en = 1'b0;
      start = 1'b1;
      n = 0; got = 0; rv_cnt = 0;
      while (!got && n < 1100) begin
         @(posedge clk); #1; n++;
         if (n == 2) start = 1'b0;
         if (result_valid) rv_cnt++;
         if (err) got = 1;
      end
      chk("to_latency", n, 1028);
      chk("to_no_rv", rv_cnt, 0);
      chk("to_result", result, r_prev);
      @(posedge clk); #1;
      chk("to_err_pulse", {err, busy}, 0);
      stub_en = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      m = 4'($urandom_range(0, 15)); a = 3'($urandom_range(0, 7)); b = 3'($urandom_range(0, 7));
      run_job(m, a, b, 1'b1, 0, 0, "after_to", r);

      // Reset in P2_WAIT; the stub's stale done lands after release
      start = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (i == 2) start = 1'b0;
      end
      chk("rst_pre_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_outs", |{tbl_msg_sel, tbl_k1_sel, tbl_k2_sel, des_start, des_decrypt,
                        des_key, des_din, busy, result, result_valid, err}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      rv_cnt = 0; act = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (result_valid || busy || err) rv_cnt++;
         if (des_start) act++;
      end
      chk("rst_stale_done", rv_cnt, 0);
      chk("rst_no_launch", act, 0);
      chk("rst_result", result, 0);
      run_job(4'h0, 3'h0, 3'h0, 1'b0, 0, 0, "post_rst", r);
      chk("post_rst_known", r, 64'h979f9bb155944075);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
